pipe_stage_skid: RTL and testbench

- Parametrised, elastic successor to the fixed stall-mux pipeline registers between stages (EX/MEM, MEM/WB).
- Replaces the global "stall → recirculate" scheme with a per-stage valid/ready handshake. A 2-entry skid buffer keeps in_ready fully registered, so a downstream stall costs no combinational path upstream.
- Adds flush, sticky-halt draining and a writeback-forwarding tap.
- Instantiated once per stage boundary; the payload is packed by the parent.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_entry_reg.sv | 21 ++
 rtl/pipe_stage_skid.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers.
// State encoding is {sv, hv}, so bit 0 is the head valid bit.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd3;

  localparam int EXMEM_W  = 32;
  localparam int MEMWB_W  = 32;
  localparam int DEF_RD_W = 3;

  // Packed payload layout used by the parent stages.
  localparam int MEMTOREG_OFF = 0;
  localparam int EXRES_OFF    = 1;
  localparam int EXRES_W      = 15;
  localparam int MEMRES_OFF   = 16;
  localparam int MEMRES_W     = 16;

  function automatic int entry_w(input int data_w, input int rd_w);
    return data_w + rd_w + 2;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Enabled entry register for one skid-buffer slot.
// Layout is {data, rd, regwrite, halt}.
module pipe_entry_reg #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a 2-entry skid buffer.
// Adds flush, sticky halt and a gated writeback tap.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RD_W        = 3,
  parameter int HALT_STICKY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regwrite,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regwrite,
  output logic              out_halt,
  output logic              halted,
  output logic [1:0]        occupancy
);

  localparam int EW = entry_w(DATA_W, RD_W);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          hv;
  logic          sv;
  logic          flush_q;
  logic          halted_q;
  logic          live_q;
  logic          acc;
  logic          pop;
  logic          h_en;
  logic          s_en;
  logic          h_sel_s;
  logic          halt_set;
  logic [EW-1:0] in_ent;
  logic [EW-1:0] h_d;
  logic [EW-1:0] h_q;
  logic [EW-1:0] s_q;

  assign hv = state[0];
  assign sv = state[1];

  // live_q holds in_ready low until the first edge out of reset.
  assign in_ready = live_q & ~sv & ~halted_q & ~flush_q;

  assign acc    = in_valid & in_ready;
  assign pop    = hv & out_ready;
  assign in_ent = {in_data, in_rd, in_regwrite, in_halt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (acc) state_nx = ST_ONE;
        ST_ONE: begin
          if (acc & ~pop) state_nx = ST_FULL;
          else if (~acc & pop) state_nx = ST_EMPTY;
        end
        ST_FULL: if (pop) state_nx = ST_ONE;
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    h_en    = 1'b0;
    s_en    = 1'b0;
    h_sel_s = 1'b0;
    if (!flush) begin
      unique case (state)
        ST_EMPTY: h_en = acc;
        ST_ONE: begin
          h_en = acc & pop;
          s_en = acc & ~pop;
        end
        ST_FULL: begin
          h_en    = pop;
          h_sel_s = 1'b1;
        end
        default: h_en = 1'b0;
      endcase
    end
  end

  assign h_d = h_sel_s ? s_q : in_ent;

  assign halt_set = (HALT_STICKY != 0) & pop & h_q[0] & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      flush_q  <= flush;
      halted_q <= halted_q | halt_set;
      live_q   <= 1'b1;
    end
  end

  pipe_entry_reg #(.W(EW)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (h_en),
    .d   (h_d),
    .q   (h_q)
  );

  pipe_entry_reg #(.W(EW)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (s_en),
    .d   (in_ent),
    .q   (s_q)
  );

  assign out_valid    = hv;
  assign out_data     = h_q[EW-1 -: DATA_W];
  assign out_rd       = h_q[2 +: RD_W];
  assign out_regwrite = hv & h_q[1];
  assign out_halt     = hv & h_q[0];
  assign halted       = halted_q;
  assign occupancy    = {1'b0, hv} + {1'b0, sv};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: vector table plus
// hand sequences for halt, async reset and non-sticky halt.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_rd;
  logic        in_regwrite;
  logic        in_halt;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_rd;
  logic        out_regwrite;
  logic        out_halt;
  logic        halted;
  logic [1:0]  occupancy;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [31:0] b_in_data;
  logic [2:0]  b_in_rd;
  logic        b_in_regwrite;
  logic        b_in_halt;
  logic        b_flush;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [31:0] b_out_data;
  logic [2:0]  b_out_rd;
  logic        b_out_regwrite;
  logic        b_out_halt;
  logic        b_halted;
  logic [1:0]  b_occupancy;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(.DATA_W(32), .RD_W(3), .HALT_STICKY(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_rd        (in_rd),
    .in_regwrite  (in_regwrite),
    .in_halt      (in_halt),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_rd       (out_rd),
    .out_regwrite (out_regwrite),
    .out_halt     (out_halt),
    .halted       (halted),
    .occupancy    (occupancy)
  );

  pipe_stage_skid #(.DATA_W(32), .RD_W(3), .HALT_STICKY(0)) dut_ns (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (b_in_valid),
    .in_ready     (b_in_ready),
    .in_data      (b_in_data),
    .in_rd        (b_in_rd),
    .in_regwrite  (b_in_regwrite),
    .in_halt      (b_in_halt),
    .flush        (b_flush),
    .out_valid    (b_out_valid),
    .out_ready    (b_out_ready),
    .out_data     (b_out_data),
    .out_rd       (b_out_rd),
    .out_regwrite (b_out_regwrite),
    .out_halt     (b_out_halt),
    .halted       (b_halted),
    .occupancy    (b_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [2:0]  rd;
    logic        ht;
    logic        fl;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  erd;
    logic        eh;
    logic        eir;
    logic [1:0]  eocc;
    logic        ehl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic iv, input logic [31:0] d, input logic [2:0] rd,
    input logic ht, input logic fl, input logic ordy,
    input logic ev, input logic [31:0] ed, input logic [2:0] erd,
    input logic eh, input logic eir, input logic [1:0] eocc,
    input logic ehl);
    vec_t v;
    v.iv = iv; v.d = d; v.rd = rd; v.ht = ht; v.fl = fl;
    v.ordy = ordy; v.ev = ev; v.ed = ed; v.erd = erd;
    v.eh = eh; v.eir = eir; v.eocc = eocc; v.ehl = ehl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // An empty head with a nonzero count is the illegal hv=0,sv=1 state.
  always @(negedge clk) begin
    if (!rst) begin
      chk("legal_state", 32'(!(!out_valid && occupancy != 2'd0)), 32'd1);
      chk("legal_state_ns",
          32'(!(!b_out_valid && b_occupancy != 2'd0)), 32'd1);
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; in_data = 0; in_rd = 0; in_regwrite = 1;
    in_halt = 0; flush = 0; out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_in_rd = 0; b_in_regwrite = 1;
    b_in_halt = 0; b_flush = 0; b_out_ready = 0;

    //        iv d        rd ht fl or  ev ed       erd eh ir occ hl
    tbl.push_back(mk(1, 32'h11, 1, 0, 0, 1, 1, 32'h11, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 32'h22, 2, 0, 0, 1, 1, 32'h22, 2, 0, 1, 1, 0));
    tbl.push_back(mk(1, 32'h33, 3, 0, 0, 1, 1, 32'h33, 3, 0, 1, 1, 0));
    tbl.push_back(mk(1, 32'h44, 4, 0, 0, 1, 1, 32'h44, 4, 0, 1, 1, 0));
    tbl.push_back(mk(1, 32'h55, 5, 0, 0, 1, 1, 32'h55, 5, 0, 1, 1, 0));
    tbl.push_back(mk(0, 32'h00, 0, 0, 0, 1, 0, 32'h55, 5, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'hA1, 1, 0, 0, 0, 1, 32'hA1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 32'hA2, 2, 0, 0, 0, 1, 32'hA1, 1, 0, 0, 2, 0));
    tbl.push_back(mk(1, 32'hA3, 3, 0, 0, 0, 1, 32'hA1, 1, 0, 0, 2, 0));
    tbl.push_back(mk(1, 32'hA3, 3, 0, 0, 1, 1, 32'hA2, 2, 0, 1, 1, 0));
    tbl.push_back(mk(1, 32'hA3, 3, 0, 0, 1, 1, 32'hA3, 3, 0, 1, 1, 0));
    tbl.push_back(mk(0, 32'h00, 0, 0, 0, 1, 0, 32'hA3, 3, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'hB0, 0, 0, 0, 0, 1, 32'hB0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 32'hB1, 1, 0, 0, 0, 1, 32'hB0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 32'hB2, 2, 0, 1, 0, 0, 32'hB0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'hB2, 2, 0, 0, 1, 0, 32'hB0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h00, 0, 0, 0, 1, 0, 32'hB0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 32'hC1, 5, 1, 0, 0, 1, 32'hC1, 5, 1, 1, 1, 0));
    tbl.push_back(mk(1, 32'hC2, 2, 0, 0, 0, 1, 32'hC1, 5, 1, 0, 2, 0));
    tbl.push_back(mk(0, 32'h00, 0, 0, 0, 1, 1, 32'hC2, 2, 0, 0, 1, 1));
    tbl.push_back(mk(1, 32'hD0, 0, 0, 0, 1, 0, 32'hC2, 2, 0, 0, 0, 1));

    #2;
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_od", out_data, 0);
    chk("rst_ir", 32'(in_ready), 0);
    chk("rst_occ", 32'(occupancy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rel_ir_low", 32'(in_ready), 0);
    step();
    chk("rel_ir_high", 32'(in_ready), 1);

    foreach (tbl[i]) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      in_rd     = tbl[i].rd;
      in_halt   = tbl[i].ht;
      flush     = tbl[i].fl;
      out_ready = tbl[i].ordy;
      step();
      chk($sformatf("v%0d ov", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d od", i), out_data, tbl[i].ed);
      chk($sformatf("v%0d ord", i), 32'(out_rd), 32'(tbl[i].erd));
      chk($sformatf("v%0d orw", i), 32'(out_regwrite), 32'(tbl[i].ev));
      chk($sformatf("v%0d oh", i), 32'(out_halt), 32'(tbl[i].eh));
      chk($sformatf("v%0d ir", i), 32'(in_ready), 32'(tbl[i].eir));
      chk($sformatf("v%0d occ", i), 32'(occupancy), 32'(tbl[i].eocc));
      chk($sformatf("v%0d hlt", i), 32'(halted), 32'(tbl[i].ehl));
    end

    in_valid = 1; in_data = 32'hE0; in_rd = 0; in_halt = 0;
    flush = 0; out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("halt_idle%0d ov", k), 32'(out_valid), 0);
      chk($sformatf("halt_idle%0d ir", k), 32'(in_ready), 0);
    end
    flush = 1;
    step();
    flush = 0;
    step();
    chk("halt_after_flush", 32'(halted), 1);
    chk("halt_after_flush_ir", 32'(in_ready), 0);

    // Async reset mid-cycle clears the sticky halt too.
    in_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst2_hlt", 32'(halted), 0);
    chk("rst2_ir", 32'(in_ready), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    chk("rel2_ir_low", 32'(in_ready), 0);
    step();
    chk("rel2_ir_high", 32'(in_ready), 1);

    in_valid = 1; in_data = 32'hE1; in_rd = 3'd1; out_ready = 0;
    step();
    in_data = 32'hE2; in_rd = 3'd2;
    step();
    chk("fill_occ", 32'(occupancy), 2);
    in_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov", 32'(out_valid), 0);
    chk("arst_od", out_data, 0);
    chk("arst_ord", 32'(out_rd), 0);
    chk("arst_orw", 32'(out_regwrite), 0);
    chk("arst_oh", 32'(out_halt), 0);
    chk("arst_occ", 32'(occupancy), 0);
    chk("arst_ir", 32'(in_ready), 0);
    #2;
    rst = 1'b0;
    chk("rel3_ir_low", 32'(in_ready), 0);
    step();
    chk("rel3_ir_high", 32'(in_ready), 1);
    chk("rel3_occ", 32'(occupancy), 0);

    // Non-sticky instance lets traffic continue past a halt.
    b_out_ready = 1;
    b_in_valid = 1; b_in_data = 32'hF1; b_in_rd = 3'd5; b_in_halt = 1;
    step();
    chk("ns_ov", 32'(b_out_valid), 1);
    chk("ns_oh", 32'(b_out_halt), 1);
    chk("ns_ord", 32'(b_out_rd), 5);
    b_in_data = 32'hF2; b_in_rd = 3'd2; b_in_halt = 0;
    step();
    chk("ns_hlt", 32'(b_halted), 0);
    chk("ns_ir", 32'(b_in_ready), 1);
    chk("ns_od2", b_out_data, 32'hF2);
    b_in_data = 32'hF3; b_in_rd = 3'd3;
    step();
    chk("ns_od3", b_out_data, 32'hF3);
    chk("ns_hlt2", 32'(b_halted), 0);
    b_in_valid = 0;
    step();
    chk("ns_empty", 32'(b_occupancy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
